// File: rtl/elevator_ctrl.sv
// N-floor elevator controller: latches calls, serves the current direction first,
// times travel and door dwell, and holds an emergency latch until reset.
module elevator_ctrl #(
    parameter int unsigned NUM_FLOORS    = 3,
    parameter int unsigned FLOOR_W       = 4,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  emerg_in,
    input  logic [NUM_FLOORS-1:0] req,
    output logic                  emerg_out,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    next_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open
);

    localparam int unsigned T_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_EMERG} state_t;

    state_t                r_state, w_state_n;
    logic [TMR_W-1:0]      r_timer, w_timer_n;
    logic [FLOOR_W-1:0]    r_cur, w_cur_n;
    logic [FLOOR_W-1:0]    r_next, w_next_n;
    logic [NUM_FLOORS-1:0] r_pend, w_pend_n;
    logic                  r_dir, w_dir_n;
    logic                  r_emerg, w_emerg_n;
    logic                  r_moving, r_door;

    logic [NUM_FLOORS-1:0] w_here, w_above, w_below, w_clr;
    logic                  w_pend_here, w_any_above, w_any_below;

    // Floor masks relative to the car position.
    always_comb begin
        w_here  = '0;
        w_above = '0;
        w_below = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_here[i]  = (FLOOR_W'(i) == r_cur);
            w_above[i] = (FLOOR_W'(i) >  r_cur);
            w_below[i] = (FLOOR_W'(i) <  r_cur);
        end
        w_pend_here = |(r_pend & w_here);
        w_any_above = |(r_pend & w_above);
        w_any_below = |(r_pend & w_below);
    end

    // Next-state and scheduling decisions.
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_cur_n   = r_cur;
        w_next_n  = r_next;
        w_dir_n   = r_dir;
        w_emerg_n = r_emerg;
        w_pend_n  = r_pend;
        w_clr     = '0;

        if (r_state != S_EMERG && emerg_in) begin
            w_state_n = S_EMERG;
            w_emerg_n = 1'b1;
            w_next_n  = r_cur;
            w_pend_n  = '0;
        end else if (r_state != S_EMERG) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pend_here) begin
                        w_state_n = S_DOOR;
                        w_timer_n = TMR_W'(DOOR_CYCLES - 1);
                        w_clr     = w_here;
                    end else if (r_dir ? w_any_above : w_any_below) begin
                        w_state_n = S_MOVE;
                        w_timer_n = TMR_W'(TRAVEL_CYCLES - 1);
                        w_next_n  = r_dir ? r_cur + FLOOR_W'(1) : r_cur - FLOOR_W'(1);
                    end else if (r_dir ? w_any_below : w_any_above) begin
                        w_state_n = S_MOVE;
                        w_timer_n = TMR_W'(TRAVEL_CYCLES - 1);
                        w_next_n  = r_dir ? r_cur - FLOOR_W'(1) : r_cur + FLOOR_W'(1);
                        w_dir_n   = ~r_dir;
                    end
                end
                S_MOVE: begin
                    if (r_timer == '0) begin
                        w_cur_n   = r_next;
                        w_state_n = S_IDLE;
                    end else begin
                        w_timer_n = r_timer - TMR_W'(1);
                    end
                end
                S_DOOR: begin
                    w_clr = w_here;
                    if (r_timer == '0) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_timer_n = r_timer - TMR_W'(1);
                    end
                end
                default: w_state_n = r_state;
            endcase
            w_pend_n = (r_pend | req) & ~w_clr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_cur    <= '0;
            r_next   <= '0;
            r_pend   <= '0;
            r_dir    <= 1'b1;
            r_emerg  <= 1'b0;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_timer  <= w_timer_n;
            r_cur    <= w_cur_n;
            r_next   <= w_next_n;
            r_pend   <= w_pend_n;
            r_dir    <= w_dir_n;
            r_emerg  <= w_emerg_n;
            r_moving <= (w_state_n == S_MOVE);
            r_door   <= (w_state_n == S_DOOR);
        end
    end

    assign emerg_out  = r_emerg;
    assign cur_floor  = r_cur;
    assign next_floor = r_next;
    assign pending    = r_pend;
    assign dir_up     = r_dir;
    assign moving     = r_moving;
    assign door_open  = r_door;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: default 3-floor car plus an 8-floor fast car.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       emerg_a = 1'b0, emerg_b = 1'b0;
    logic [2:0] req_a = '0;
    logic [7:0] req_b = '0;

    logic       eo_a, dir_a, mov_a, door_a;
    logic [3:0] cur_a, next_a;
    logic [2:0] pend_a;
    logic       eo_b, dir_b, mov_b, door_b;
    logic [2:0] cur_b, next_b;
    logic [7:0] pend_b;

    elevator_ctrl u_dut_a (
        .clk(clk), .reset(reset), .emerg_in(emerg_a), .req(req_a),
        .emerg_out(eo_a), .cur_floor(cur_a), .next_floor(next_a), .pending(pend_a),
        .dir_up(dir_a), .moving(mov_a), .door_open(door_a)
    );

    elevator_ctrl #(.NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(1), .DOOR_CYCLES(1)) u_dut_b (
        .clk(clk), .reset(reset), .emerg_in(emerg_b), .req(req_b),
        .emerg_out(eo_b), .cur_floor(cur_b), .next_floor(next_b), .pending(pend_b),
        .dir_up(dir_b), .moving(mov_b), .door_open(door_b)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] M_CUR  = 32'h0000F;
    localparam logic [31:0] M_NEXT = 32'h000F0;
    localparam logic [31:0] M_PEND = 32'h0FF00;
    localparam logic [31:0] M_DIR  = 32'h10000;
    localparam logic [31:0] M_MOV  = 32'h20000;
    localparam logic [31:0] M_DOOR = 32'h40000;
    localparam logic [31:0] M_EMG  = 32'h80000;
    localparam logic [31:0] M_ALL  = 32'hFFFFF;

    typedef struct {
        int          cyc;
        int          dut;
        string       nm;
        logic [31:0] exp;
        logic [31:0] msk;
    } chk_t;

    chk_t        sb_q[$];
    chk_t        mon_e;
    logic [31:0] mon_obs;
    int          cyc = 0;
    int          c0 = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    wire [31:0] obs_a = {12'd0, eo_a, door_a, mov_a, dir_a, 5'd0, pend_a, next_a, cur_a};
    wire [31:0] obs_b = {12'd0, eo_b, door_b, mov_b, dir_b, pend_b, 1'b0, next_b, 1'b0, cur_b};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ob(int cur, int nxt, int pend, int dir, int mov, int door, int emg);
        return 32'(cur) | (32'(nxt) << 4) | (32'(pend) << 8) | (32'(dir) << 16)
             | (32'(mov) << 17) | (32'(door) << 18) | (32'(emg) << 19);
    endfunction

    task automatic push(input int k, input int dut, input string nm, input logic [31:0] e, input logic [31:0] m);
        sb_q.push_back('{c0 + k, dut, nm, e, m});
    endtask

    task automatic start_test();
        c0 = cyc + 1;
    endtask

    task automatic wait_k(input int k);
        while (cyc < c0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assert reset between edges; the check lands on the next negedge, before any clk rise.
    task automatic async_reset(input string nm);
        #2;
        reset = 1'b1;
        sb_q.push_back('{cyc, 0, {nm, "_a"}, ob(0, 0, 0, 1, 0, 0, 0), M_ALL});
        sb_q.push_back('{cyc, 1, {nm, "_b"}, ob(0, 0, 0, 1, 0, 0, 0), M_ALL});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every expectation whose cycle slot has arrived.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e   = sb_q.pop_front();
            mon_obs = (mon_e.dut == 0) ? obs_a : obs_b;
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_miss++;
                $display("FAIL %s: slot %0d missed, now cycle %0d", mon_e.nm, mon_e.cyc, cyc);
            end else if ((mon_obs & mon_e.msk) !== (mon_e.exp & mon_e.msk)) begin
                n_miss++;
                $display("FAIL %s: got %05h required %05h (mask %05h)",
                         mon_e.nm, mon_obs & mon_e.msk, mon_e.exp & mon_e.msk, mon_e.msk);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        async_reset("reset_init");

        // Single call to floor 2 from floor 0.
        start_test();
        req_a = 3'b100;
        push(1,  0, "call_move1",  ob(0, 1, 4, 0, 1, 0, 0), M_CUR | M_NEXT | M_MOV | M_PEND);
        push(4,  0, "call_still",  ob(0, 0, 0, 0, 1, 0, 0), M_CUR | M_MOV);
        push(5,  0, "call_at1",    ob(1, 1, 0, 0, 0, 0, 0), M_CUR | M_NEXT | M_MOV);
        push(6,  0, "call_move2",  ob(1, 2, 0, 0, 1, 0, 0), M_CUR | M_NEXT | M_MOV);
        push(10, 0, "call_at2",    ob(2, 2, 4, 0, 0, 0, 0), M_CUR | M_NEXT | M_MOV | M_DOOR | M_PEND);
        push(11, 0, "call_door",   ob(2, 0, 0, 0, 0, 1, 0), M_CUR | M_DOOR | M_PEND | M_MOV);
        push(13, 0, "call_dwell",  ob(0, 0, 0, 0, 0, 1, 0), M_DOOR);
        push(14, 0, "call_close",  ob(0, 0, 0, 0, 0, 0, 0), M_DOOR | M_MOV);
        wait_k(1);
        req_a = '0;
        wait_k(15);

        async_reset("reset_f2");

        // Call at the current floor, held through the door time.
        start_test();
        req_a = 3'b001;
        push(0, 0, "here_latch",   ob(0, 0, 1, 0, 0, 0, 0), M_PEND | M_DOOR);
        push(1, 0, "here_open",    ob(0, 0, 0, 0, 0, 1, 0), M_PEND | M_DOOR);
        push(3, 0, "here_absorb",  ob(0, 0, 0, 0, 0, 1, 0), M_PEND | M_DOOR);
        push(4, 0, "here_close",   ob(0, 0, 0, 0, 0, 0, 0), M_PEND | M_DOOR);
        push(6, 0, "here_noreopn", ob(0, 0, 0, 0, 0, 0, 0), M_PEND | M_DOOR | M_MOV);
        wait_k(3);
        req_a = '0;
        wait_k(7);

        // Direction preference: up to 2 first, then back down to 0.
        start_test();
        req_a = 3'b100;
        push(5,  0, "dir_at1",     ob(1, 0, 5, 1, 0, 0, 0), M_CUR | M_PEND | M_DIR | M_MOV);
        push(6,  0, "dir_upfirst", ob(1, 2, 0, 1, 1, 0, 0), M_CUR | M_NEXT | M_DIR | M_MOV);
        push(11, 0, "dir_door2",   ob(2, 0, 1, 1, 0, 1, 0), M_CUR | M_PEND | M_DIR | M_DOOR);
        push(14, 0, "dir_idle2",   ob(2, 2, 1, 1, 0, 0, 0), M_CUR | M_NEXT | M_DIR | M_DOOR | M_MOV);
        push(15, 0, "dir_flip",    ob(2, 1, 0, 0, 1, 0, 0), M_CUR | M_NEXT | M_DIR | M_MOV);
        push(24, 0, "dir_at0",     ob(0, 0, 1, 0, 0, 0, 0), M_CUR | M_NEXT | M_DIR | M_MOV | M_PEND);
        push(25, 0, "dir_door0",   ob(0, 0, 0, 0, 0, 1, 0), M_CUR | M_PEND | M_DOOR);
        wait_k(1);
        req_a = '0;
        wait_k(2);
        req_a = 3'b001;
        wait_k(3);
        req_a = '0;
        wait_k(29);

        // Emergency in the second MOVE cycle from floor 0 to 1.
        start_test();
        req_a = 3'b010;
        push(1, 0, "em_move",  ob(0, 1, 0, 1, 1, 0, 0), M_CUR | M_NEXT | M_MOV | M_DIR);
        push(3, 0, "em_latch", ob(0, 0, 0, 0, 0, 0, 1), M_CUR | M_NEXT | M_PEND | M_MOV | M_DOOR | M_EMG);
        push(8, 0, "em_hold",  ob(0, 0, 0, 0, 0, 0, 1), M_CUR | M_NEXT | M_PEND | M_MOV | M_DOOR | M_EMG);
        wait_k(1);
        req_a = '0;
        wait_k(2);
        emerg_a = 1'b1;
        req_a   = 3'b100;
        wait_k(3);
        emerg_a = 1'b0;
        req_a   = 3'b111;
        wait_k(8);
        req_a = '0;
        wait_k(9);

        async_reset("reset_emerg");

        // Eight-floor car, one-cycle travel and door: floor 0 to 7.
        start_test();
        req_b = 8'h80;
        push(1,  1, "sw_move1", ob(0, 1, 128, 0, 1, 0, 0), M_CUR | M_NEXT | M_MOV | M_PEND);
        push(2,  1, "sw_at1",   ob(1, 0, 0, 0, 0, 0, 0), M_CUR | M_MOV);
        push(13, 1, "sw_move7", ob(6, 7, 0, 0, 1, 0, 0), M_CUR | M_NEXT | M_MOV);
        push(14, 1, "sw_at7",   ob(7, 7, 128, 1, 0, 0, 0), M_CUR | M_NEXT | M_MOV | M_DIR | M_PEND);
        push(15, 1, "sw_door",  ob(7, 7, 0, 0, 0, 1, 0), M_CUR | M_NEXT | M_PEND | M_DOOR);
        push(16, 1, "sw_close", ob(7, 7, 0, 1, 0, 0, 0), M_CUR | M_NEXT | M_DIR | M_DOOR | M_MOV);
        wait_k(1);
        req_b = '0;
        wait_k(18);

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
            n_miss += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
